wrr_port_lookup: RTL and testbench

- Stage directly downstream of the WRR input arbiter in the switch user datapath.
- Buffers the arbiter's packet stream and rewrites the one-hot destination-port field of the IOQ module header, using the source port: MAC ingress floods the other MAC ports; CPU ingress goes to its paired MAC port.
- All other words pass through unchanged. Output feeds the output-queue stage with the same data/ctrl/wr/rdy interface.

---
 rtl/wrr_port_lookup_if.sv | 43 ++++
 rtl/wrr_port_lookup.sv | 240 ++++++++++++++++++++++++
 tb/tb_wrr_port_lookup.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wrr_port_lookup_if.sv
// ---------------------------------------------------------------------------
// wrr_port_lookup_if
//
// Purpose:
//   Word-stream bus used between datapath stages of the switch user datapath.
//   The sender drives a word, its ctrl tag and a write strobe. The receiver
//   drives rdy to say it can take another word.
//
// Signals:
//   data  DATA_WIDTH  datapath word
//   ctrl  CTRL_WIDTH  ctrl tag (module header id, 0 for payload, eop marker)
//   wr    1           write strobe, one word per cycle while high
//   rdy   1           receiver can accept a word
//
// Modports:
//   master  drives data/ctrl/wr and observes rdy (word producer)
//   slave   observes data/ctrl/wr and drives rdy (word consumer)
// ---------------------------------------------------------------------------
interface wrr_port_lookup_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);

  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  wr;
  logic                  rdy;

  modport master (
    output data,
    output ctrl,
    output wr,
    input  rdy
  );

  modport slave (
    input  data,
    input  ctrl,
    input  wr,
    output rdy
  );

endinterface

// File: rtl/wrr_port_lookup.sv
// ---------------------------------------------------------------------------
// wrr_port_lookup
//
// Purpose:
//   Sits right after the WRR input arbiter. Buffers the arbiter's word stream
//   in a small FIFO and, while a packet's module headers go past, rewrites the
//   one-hot destination-port field of each IOQ module header from the binary
//   source-port field:
//     - MAC ingress (even src_port) floods every other MAC port,
//     - CPU ingress (odd src_port) goes to its paired MAC port,
//     - an out-of-range src_port yields an empty destination set.
//   Every other word passes through untouched.
//
// IOQ header layout: [63:48] dst_port one-hot, [47:32] word_len,
//                    [31:16] src_port binary, [15:0] byte_len.
//
// Ports:
//   clk            in   datapath clock
//   reset          in   asynchronous active-low reset
//   in_bus         slave  word stream from the arbiter (in_rdy = bus rdy)
//   out_bus        master word stream to the output-queue stage
//   pkt_count      out  32-bit count of packets forwarded (stats build)
//   bad_src_count  out  32-bit count of IOQ headers with invalid src_port
//
// Build option:
//   WRR_LOOKUP_STATS_EN  when defined, the two statistics counters are built;
//                        when undefined, both counter ports are tied to zero.
//                        Forwarding is identical in both builds.
//
// Assumes DATA_WIDTH >= 64 and NUM_MAC_PORTS <= 8 (16-bit port fields).
// ---------------------------------------------------------------------------
module wrr_port_lookup #(
  parameter int                      DATA_WIDTH      = 64,
  parameter int                      CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter logic [CTRL_WIDTH-1:0]   IOQ_STAGE_NUM   = CTRL_WIDTH'(8'hFF),
  parameter int                      NUM_MAC_PORTS   = 4,
  parameter int                      FIFO_DEPTH_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  wrr_port_lookup_if.slave    in_bus,
  wrr_port_lookup_if.master   out_bus,
  output logic [31:0]         pkt_count,
  output logic [31:0]         bad_src_count
);

  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int WORD_WIDTH = CTRL_WIDTH + DATA_WIDTH;
  localparam int NUM_PORTS  = 2 * NUM_MAC_PORTS;

  localparam logic [FIFO_DEPTH_BITS:0]   CNT_ONE         = (FIFO_DEPTH_BITS + 1)'(1);
  localparam logic [FIFO_DEPTH_BITS:0]   CNT_FULL        = (FIFO_DEPTH_BITS + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_DEPTH_BITS:0]   CNT_NEARLY_FULL = CNT_FULL - CNT_ONE;
  localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE         = FIFO_DEPTH_BITS'(1);

  // Packet parser states
  localparam logic [0:0] MODULE_HDRS = 1'b0;
  localparam logic [0:0] IN_PACKET   = 1'b1;

  // Flood mask for MAC ingress: every even (MAC) port bit that exists.
  function automatic logic [15:0] macFloodMask();
    logic [15:0] mask;
    mask = '0;
    for (int i = 0; i < 16; i++) begin
      mask[i] = ((i % 2) == 0) && (i < NUM_PORTS);
    end
    return mask;
  endfunction

  localparam logic [15:0] MAC_MASK = macFloodMask();

  // FIFO storage and bookkeeping
  logic [WORD_WIDTH-1:0]      r_fifoMem [FIFO_DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] r_wrPtr;
  logic [FIFO_DEPTH_BITS-1:0] r_rdPtr;
  logic [FIFO_DEPTH_BITS:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_nearlyFull;
  logic w_push;
  logic w_pop;

  // Head-of-FIFO word and lookup results
  logic [WORD_WIDTH-1:0] w_headWord;
  logic [CTRL_WIDTH-1:0] w_headCtrl;
  logic [DATA_WIDTH-1:0] w_headData;
  logic [15:0]           w_srcPort;
  logic                  w_srcValid;
  logic [15:0]           w_dstPort;
  logic                  w_isIoqHdr;
  logic [DATA_WIDTH-1:0] w_outData;

  // Parser state and registered output stage
  logic [0:0]            r_state;
  logic                  r_outWr;
  logic [DATA_WIDTH-1:0] r_outData;
  logic [CTRL_WIDTH-1:0] r_outCtrl;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CNT_FULL);
  // Leave one entry of slack so a word already in flight from the arbiter
  // when rdy falls still has somewhere to land.
  assign w_nearlyFull = (r_count >= CNT_NEARLY_FULL);
  assign in_bus.rdy   = !w_nearlyFull;

  assign w_pop  = !w_empty && out_bus.rdy;
  // A write into a full FIFO is only taken when a pop frees the slot on the
  // same edge; otherwise the word is dropped and the FIFO is left alone.
  assign w_push = in_bus.wr && (!w_full || w_pop);

  // FIFO storage: plain memory, no reset needed since the count guards reads
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoMem[r_wrPtr] <= {in_bus.ctrl, in_bus.data};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_headWord = r_fifoMem[r_rdPtr];
  assign w_headCtrl = w_headWord[WORD_WIDTH-1 -: CTRL_WIDTH];
  assign w_headData = w_headWord[DATA_WIDTH-1:0];
  assign w_srcPort  = w_headData[31:16];
  assign w_isIoqHdr = (r_state == MODULE_HDRS) && (w_headCtrl == IOQ_STAGE_NUM);

  // Destination lookup. Port numbering interleaves MAC (even) and CPU (odd)
  // ports, so CPU port s pairs with MAC port s-1.
  always_comb begin
    w_srcValid = (w_srcPort < 16'(NUM_PORTS));
    w_dstPort  = 16'h0000;
    if (w_srcValid) begin
      if (!w_srcPort[0]) begin
        w_dstPort = MAC_MASK & ~(16'd1 << w_srcPort[3:0]);
      end else begin
        w_dstPort = 16'd1 << (w_srcPort[3:0] - 4'd1);
      end
    end
  end

  // Only the dst_port field of an IOQ header changes; all else is copied.
  always_comb begin
    w_outData = w_headData;
    if (w_isIoqHdr) begin
      w_outData[63:48] = w_dstPort;
    end
  end

  // Packet parser: headers carry nonzero ctrl, the first ctrl==0 word starts
  // the payload, and the next nonzero ctrl in the payload marks eop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= MODULE_HDRS;
    end else if (w_pop) begin
      case (r_state)
        MODULE_HDRS: begin
          if (w_headCtrl == '0) begin
            r_state <= IN_PACKET;
          end
        end
        IN_PACKET: begin
          if (w_headCtrl != '0) begin
            r_state <= MODULE_HDRS;
          end
        end
        default: r_state <= MODULE_HDRS;
      endcase
    end
  end

  // Output register: strobe follows the pop; data holds between words
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outWr   <= 1'b0;
      r_outData <= '0;
      r_outCtrl <= '0;
    end else begin
      r_outWr <= w_pop;
      if (w_pop) begin
        r_outData <= w_outData;
        r_outCtrl <= w_headCtrl;
      end
    end
  end

  assign out_bus.wr   = r_outWr;
  assign out_bus.data = r_outData;
  assign out_bus.ctrl = r_outCtrl;

`ifdef WRR_LOOKUP_STATS_EN
  logic        w_pktEnd;
  logic        w_badSrc;
  logic [31:0] r_pktCount;
  logic [31:0] r_badSrcCount;

  assign w_pktEnd = w_pop && (r_state == IN_PACKET) && (w_headCtrl != '0);
  assign w_badSrc = w_pop && w_isIoqHdr && !w_srcValid;

  // Statistics counters, free-running and wrapping at 2^32
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pktCount    <= 32'h0;
      r_badSrcCount <= 32'h0;
    end else begin
      if (w_pktEnd) begin
        r_pktCount <= r_pktCount + 32'd1;
      end
      if (w_badSrc) begin
        r_badSrcCount <= r_badSrcCount + 32'd1;
      end
    end
  end

  assign pkt_count     = r_pktCount;
  assign bad_src_count = r_badSrcCount;
`else
  assign pkt_count     = 32'h0;
  assign bad_src_count = 32'h0;
`endif

endmodule

// File: tb/tb_wrr_port_lookup.sv
// ---------------------------------------------------------------------------
// tb_wrr_port_lookup
//
// Purpose:
//   Self-checking bench for wrr_port_lookup. A table of IOQ-header vectors
//   with hand-computed destination masks drives three-word packets; hand
//   sequences cover backpressure, FIFO overflow, strobe toggling, stacked
//   IOQ headers and a reset in the middle of a packet. Output words are
//   collected by a monitor and compared against an expected-word queue.
// ---------------------------------------------------------------------------
module tb_wrr_port_lookup;

  localparam int DW = 64;
  localparam int CW = 8;

  logic        clk;
  logic        reset;
  logic [31:0] pktCount;
  logic [31:0] badSrcCount;

  int checks = 0;
  int errors = 0;
  int expPkts = 0;
  int expBad = 0;

  logic [71:0] actQ[$];
  logic [71:0] expQ[$];

  typedef struct {
    logic [7:0]  hdrCtrl;
    logic [15:0] srcPort;
    logic [15:0] expDst;
  } vec_t;

  vec_t vecs[12];

  wrr_port_lookup_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) inBus();
  wrr_port_lookup_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) outBus();

  wrr_port_lookup #(
    .DATA_WIDTH      (DW),
    .CTRL_WIDTH      (CW),
    .IOQ_STAGE_NUM   (8'hFF),
    .NUM_MAC_PORTS   (4),
    .FIFO_DEPTH_BITS (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_bus        (inBus),
    .out_bus       (outBus),
    .pkt_count     (pktCount),
    .bad_src_count (badSrcCount)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: capture each output word mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (outBus.wr === 1'b1) begin
      actQ.push_back({outBus.ctrl, outBus.data});
    end
  end

  // Safety net so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Counter expectations depend on whether the stats build is in use
  function automatic logic [31:0] statExp(input int v);
`ifdef WRR_LOOKUP_STATS_EN
    return 32'(v);
`else
    return 32'(v) & 32'h0;
`endif
  endfunction

  function automatic logic [63:0] ioqHdr(input logic [15:0] dst, input logic [15:0] src);
    return {dst, 16'h0004, src, 16'h0020};
  endfunction

  task automatic checkVal(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one word regardless of rdy; starts and ends at posedge+1
  task automatic writeRaw(input logic [7:0] ctrl, input logic [63:0] data);
    inBus.wr   = 1'b1;
    inBus.ctrl = ctrl;
    inBus.data = data;
    @(posedge clk);
    #1;
    inBus.wr = 1'b0;
  endtask

  // Drive one word the way the arbiter does: wait for rdy first (bounded)
  task automatic sendWord(input logic [7:0] ctrl, input logic [63:0] data);
    int n;
    n = 0;
    while (!inBus.rdy && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_timeout actual=rdy_low required=rdy_high");
    end else begin
      writeRaw(ctrl, data);
    end
  endtask

  // Wait (bounded) for the expected words, then compare in order
  task automatic checkOutput(input string name);
    int n;
    n = 0;
    while (actQ.size() < expQ.size() && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    idle(4);
    checkVal({name, "_count"}, 72'(actQ.size()), 72'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < actQ.size(); i++) begin
      checkVal($sformatf("%s_word%0d", name, i), actQ[i], expQ[i]);
    end
    actQ.delete();
    expQ.delete();
  endtask

  task automatic checkCounters(input string name);
    checkVal({name, "_pkt_count"}, 72'(pktCount), 72'(statExp(expPkts)));
    checkVal({name, "_bad_src_count"}, 72'(badSrcCount), 72'(statExp(expBad)));
  endtask

  // One three-word packet per table vector: header, payload, eop
  task automatic applyStimulus(input vec_t v, input int idx);
    logic [63:0] hdr;
    logic [63:0] pay0;
    logic [63:0] pay1;
    hdr  = ioqHdr(16'hA5A5, v.srcPort);
    pay0 = 64'h1111_0000_0000_0000 + 64'(idx);
    pay1 = 64'h2222_0000_0000_0000 + 64'(idx);
    sendWord(v.hdrCtrl, hdr);
    sendWord(8'h00, pay0);
    sendWord(8'h80, pay1);
    expQ.push_back({v.hdrCtrl, v.expDst, hdr[47:0]});
    expQ.push_back({8'h00, pay0});
    expQ.push_back({8'h80, pay1});
    expPkts++;
    if (v.hdrCtrl == 8'hFF && v.srcPort >= 16'd8) begin
      expBad++;
    end
  endtask

  initial begin
    logic [71:0] burst[10];
    logic [63:0] hdr;

    vecs[0]  = '{8'hFF, 16'd0,      16'h0054};
    vecs[1]  = '{8'hFF, 16'd1,      16'h0001};
    vecs[2]  = '{8'hFF, 16'd2,      16'h0051};
    vecs[3]  = '{8'hFF, 16'd3,      16'h0004};
    vecs[4]  = '{8'hFF, 16'd4,      16'h0045};
    vecs[5]  = '{8'hFF, 16'd5,      16'h0010};
    vecs[6]  = '{8'hFF, 16'd6,      16'h0015};
    vecs[7]  = '{8'hFF, 16'd7,      16'h0040};
    vecs[8]  = '{8'hFF, 16'd8,      16'h0000};
    vecs[9]  = '{8'hFF, 16'd9,      16'h0000};
    vecs[10] = '{8'hFF, 16'hFFFF,   16'h0000};
    vecs[11] = '{8'h10, 16'd9,      16'hA5A5};

    inBus.wr   = 1'b0;
    inBus.ctrl = '0;
    inBus.data = '0;
    outBus.rdy = 1'b1;
    reset      = 1'b1;
    #1;
    reset = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkVal("rst_out_wr",   72'(outBus.wr),   72'(0));
    checkVal("rst_out_data", 72'(outBus.data), 72'(0));
    checkVal("rst_out_ctrl", 72'(outBus.ctrl), 72'(0));
    checkCounters("rst");
    reset = 1'b1;
    idle(1);
    checkVal("rst_in_rdy", 72'(inBus.rdy), 72'(1));

    // Table-driven lookup vectors
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], i);
      checkOutput($sformatf("vec%0d", i));
    end
    checkCounters("table");

    // Burst with out_rdy low: fill, overflow, then pop+push on a full FIFO
    for (int i = 0; i < 10; i++) begin
      burst[i] = {8'h00, 64'hB000_0000_0000_0000 + 64'(i)};
    end
    burst[0] = {8'hFF, ioqHdr(16'h0000, 16'd3)};
    burst[9] = {8'h80, 64'hB000_0000_0000_0009};
    outBus.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sendWord(burst[i][71:64], burst[i][63:0]);
    end
    checkVal("burst_rdy_low_at_3", 72'(inBus.rdy), 72'(0));
    writeRaw(burst[3][71:64], burst[3][63:0]);
    writeRaw(burst[4][71:64], burst[4][63:0]);
    checkVal("burst_no_out_while_stalled", 72'(actQ.size()), 72'(0));
    outBus.rdy = 1'b1;
    writeRaw(burst[5][71:64], burst[5][63:0]);
    for (int i = 6; i < 10; i++) begin
      sendWord(burst[i][71:64], burst[i][63:0]);
    end
    expQ.push_back({8'hFF, 16'h0004, burst[0][47:0]});
    for (int i = 1; i < 10; i++) begin
      if (i != 4) begin
        expQ.push_back(burst[i]);
      end
    end
    expPkts++;
    checkOutput("burst");

    // Toggle out_rdy every cycle while a 6-word packet goes in
    hdr = ioqHdr(16'h1234, 16'd7);
    fork
      begin
        for (int t = 0; t < 40; t++) begin
          outBus.rdy = ~outBus.rdy;
          @(posedge clk);
          #1;
        end
        outBus.rdy = 1'b1;
      end
      begin
        sendWord(8'hFF, hdr);
        for (int k = 1; k < 5; k++) begin
          sendWord(8'h00, 64'hC000_0000_0000_0000 + 64'(k));
        end
        sendWord(8'h40, 64'hC000_0000_0000_0005);
      end
    join
    expQ.push_back({8'hFF, 16'h0040, hdr[47:0]});
    for (int k = 1; k < 5; k++) begin
      expQ.push_back({8'h00, 64'hC000_0000_0000_0000 + 64'(k)});
    end
    expQ.push_back({8'h40, 64'hC000_0000_0000_0005});
    expPkts++;
    checkOutput("toggle");

    // Two IOQ headers in one packet, each rewritten on its own
    sendWord(8'hFF, ioqHdr(16'hFFFF, 16'd1));
    sendWord(8'hFF, ioqHdr(16'hFFFF, 16'd4));
    sendWord(8'h00, 64'hD000_0000_0000_0001);
    sendWord(8'h80, 64'hD000_0000_0000_0002);
    expQ.push_back({8'hFF, ioqHdr(16'h0001, 16'd1)});
    expQ.push_back({8'hFF, ioqHdr(16'h0045, 16'd4)});
    expQ.push_back({8'h00, 64'hD000_0000_0000_0001});
    expQ.push_back({8'h80, 64'hD000_0000_0000_0002});
    expPkts++;
    checkOutput("dual_hdr");
    checkCounters("mid");

    // Reset in the middle of a packet with words still queued
    sendWord(8'hFF, ioqHdr(16'h0000, 16'd2));
    sendWord(8'h00, 64'hE000_0000_0000_0001);
    sendWord(8'h00, 64'hE000_0000_0000_0002);
    expQ.push_back({8'hFF, ioqHdr(16'h0051, 16'd2)});
    expQ.push_back({8'h00, 64'hE000_0000_0000_0001});
    expQ.push_back({8'h00, 64'hE000_0000_0000_0002});
    checkOutput("pre_rst");
    outBus.rdy = 1'b0;
    sendWord(8'h00, 64'hE000_0000_0000_0003);
    sendWord(8'h00, 64'hE000_0000_0000_0004);
    idle(1);
    reset = 1'b0;
    #2;
    expPkts = 0;
    expBad = 0;
    checkVal("midrst_out_wr",   72'(outBus.wr),   72'(0));
    checkVal("midrst_out_data", 72'(outBus.data), 72'(0));
    checkVal("midrst_in_rdy",   72'(inBus.rdy),   72'(1));
    checkCounters("midrst");
    idle(2);
    reset = 1'b1;
    outBus.rdy = 1'b1;
    idle(5);
    checkVal("midrst_fifo_empty", 72'(actQ.size()), 72'(0));
    actQ.delete();
    hdr = ioqHdr(16'h0000, 16'd6);
    sendWord(8'hFF, hdr);
    sendWord(8'h00, 64'hF000_0000_0000_0001);
    sendWord(8'h80, 64'hF000_0000_0000_0002);
    expQ.push_back({8'hFF, 16'h0015, hdr[47:0]});
    expQ.push_back({8'h00, 64'hF000_0000_0000_0001});
    expQ.push_back({8'h80, 64'hF000_0000_0000_0002});
    expPkts++;
    checkOutput("post_rst");
    checkCounters("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
